// File: rtl/counter_mod_updown_if.sv
// Bus bundle for counter_mod_updown: control inputs and registered outputs.
interface counter_mod_updown_if #(
    parameter int N = 3
) ();
    logic         ce;
    logic         up;
    logic         load;
    logic [N-1:0] din;
    logic [N-1:0] q;
    logic         ov;
    logic         done;

    modport master (
        output ce, up, load, din,
        input  q, ov, done
    );

    modport slave (
        input  ce, up, load, din,
        output q, ov, done
    );
endinterface

// File: rtl/counter_mod_updown.sv
// Modulo-MOD up/down counter with parallel load, clock-enable prescaler,
// and optional one-shot (stop at terminal count) behaviour.
module counter_mod_updown #(
    parameter int N        = 3,
    parameter int MOD      = 8,
    parameter int PRESCALE = 1,
    parameter int ONESHOT  = 0
) (
    input logic                 clk,
    input logic                 rst,
    counter_mod_updown_if.slave bus
);

    localparam int             PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [N-1:0]   TOP      = N'(MOD - 1);
    localparam logic [N:0]     MOD_W    = (N+1)'(MOD);
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
    localparam bit             IS_ONESHOT = (ONESHOT != 0);

    logic [N-1:0]  q_q,    q_d;
    logic [PW-1:0] pre_q,  pre_d;
    logic          ov_q,   ov_d;
    logic          done_q, done_d;
    logic          tick;

    // Next-state: load overrides a tick; terminal events wrap or stop.
    always_comb begin
        q_d    = q_q;
        pre_d  = pre_q;
        ov_d   = 1'b0;
        done_d = done_q;
        tick   = bus.ce && (pre_q == PRE_LAST);

        if (bus.load) begin
            q_d    = ({1'b0, bus.din} >= MOD_W) ? TOP : bus.din;
            pre_d  = '0;
            done_d = 1'b0;
        end else begin
            if (bus.ce) begin
                pre_d = tick ? '0 : pre_q + PW'(1);
            end
            // Once done, ticks still advance the prescaler but never q/ov.
            if (tick && !done_q) begin
                if (bus.up) begin
                    if (q_q == TOP) begin
                        ov_d = 1'b1;
                        if (IS_ONESHOT) done_d = 1'b1;
                        else            q_d    = '0;
                    end else begin
                        q_d = q_q + N'(1);
                    end
                end else begin
                    if (q_q == '0) begin
                        ov_d = 1'b1;
                        if (IS_ONESHOT) done_d = 1'b1;
                        else            q_d    = TOP;
                    end else begin
                        q_d = q_q - N'(1);
                    end
                end
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            pre_q  <= '0;
            ov_q   <= 1'b0;
            done_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            pre_q  <= pre_d;
            ov_q   <= ov_d;
            done_q <= done_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.ov   = ov_q;
    assign bus.done = done_q;

endmodule
